// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the three buses around the data-RAM arbiter.
//   cpu_*  : processor memory port (req/wen/addr/wdata in, stall/rdata out)
//   io_*   : I/O master port (req/lock/wen/addr/wdata in, gnt/rvalid/rdata out)
//   mem_*  : single-port RAM (wen/addr/wdata out, rdata in with 1-cycle latency)
// Modports:
//   slave  : arbiter view
//   master : environment view (CPU, I/O master and RAM together)
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_wen;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic [DATA_W-1:0] cpu_rdata;

   logic              io_req;
   logic              io_lock;
   logic              io_wen;
   logic [ADDR_W-1:0] io_addr;
   logic [DATA_W-1:0] io_wdata;
   logic              io_gnt;
   logic              io_rvalid;
   logic [DATA_W-1:0] io_rdata;

   logic              mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
      output cpu_stall, cpu_rdata,
      input  io_req, io_lock, io_wen, io_addr, io_wdata,
      output io_gnt, io_rvalid, io_rdata,
      output mem_wen, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
      input  cpu_stall, cpu_rdata,
      output io_req, io_lock, io_wen, io_addr, io_wdata,
      input  io_gnt, io_rvalid, io_rdata,
      input  mem_wen, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU memory port and
// an I/O master. One requester is granted per cycle; the loser is stalled.
// Supports locked I/O bursts (bounded while the CPU waits) and an I/O
// starvation counter that forces an I/O grant after STARVE_MAX denied cycles.
//
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : dmem_arbiter_if.slave (cpu_*, io_*, mem_* signal groups)
//
// Build option:
//   DMEM_ARB_RR_EN : when defined, simultaneous CPU/I-O requests alternate
//                    (least recently granted wins) and the starvation rule is
//                    removed; starve_cnt stays at 0. Burst rules are unchanged.
module dmem_arbiter #(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 8,
   parameter int unsigned BURST_MAX  = 4
) (
   input logic          clock,
   input logic          reset,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {ArbIdle, ArbCpu, ArbIo, ArbIoBurst} arb_state_e;
   typedef enum logic [1:0] {OwnNone, OwnCpu, OwnIo} rd_owner_e;

   localparam logic [7:0] StarveMax = 8'(STARVE_MAX);
   localparam logic [7:0] BurstMax  = 8'(BURST_MAX);

   arb_state_e state_q, state_d;
   rd_owner_e  rd_owner_q, rd_owner_d;
   logic [7:0] starve_cnt_q, starve_cnt_d;
   logic [7:0] burst_cnt_q, burst_cnt_d;

   logic cpu_granted;
   logic io_granted;
   logic rule_burst;

`ifdef DMEM_ARB_RR_EN
   // Set when the I/O master was the most recent winner.
   logic last_io_q, last_io_d;
`else
   logic rule_starve;
`endif

   // ---------------------------------------------------------------------
   // Grant decision (combinational, one-hot or none)
   // ---------------------------------------------------------------------
   always_comb begin
      rule_burst = (state_q == ArbIoBurst) && bus.io_req && bus.io_lock &&
                   (!bus.cpu_req || (burst_cnt_q < BurstMax));
`ifdef DMEM_ARB_RR_EN
      // On contention the requester that did not win last time gets the RAM.
      io_granted = rule_burst || (bus.io_req && (!bus.cpu_req || !last_io_q));
`else
      rule_starve = (starve_cnt_q == StarveMax) && bus.io_req;
      io_granted  = rule_burst || rule_starve || (bus.io_req && !bus.cpu_req);
`endif
      cpu_granted = bus.cpu_req && !io_granted;
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d      = ArbIdle;
      burst_cnt_d  = burst_cnt_q;
      starve_cnt_d = starve_cnt_q;
      rd_owner_d   = OwnNone;

      if (io_granted) begin
         state_d = bus.io_lock ? ArbIoBurst : ArbIo;
      end else if (cpu_granted) begin
         state_d = ArbCpu;
      end

      // Entry beat of a burst restarts the count; only beats taken while the
      // CPU is waiting are counted against BURST_MAX.
      if ((state_d == ArbIoBurst) && (state_q != ArbIoBurst)) begin
         burst_cnt_d = '0;
      end else if ((state_q == ArbIoBurst) && io_granted && bus.io_lock && bus.cpu_req &&
                   (burst_cnt_q < BurstMax)) begin
         burst_cnt_d = burst_cnt_q + 8'd1;
      end

`ifdef DMEM_ARB_RR_EN
      starve_cnt_d = '0;
`else
      if (!bus.io_req || io_granted) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q < StarveMax) begin
         starve_cnt_d = starve_cnt_q + 8'd1;
      end
`endif

      if (io_granted && !bus.io_wen) begin
         rd_owner_d = OwnIo;
      end else if (cpu_granted && !bus.cpu_wen) begin
         rd_owner_d = OwnCpu;
      end
   end

`ifdef DMEM_ARB_RR_EN
   always_comb begin
      last_io_d = last_io_q;
      if (io_granted) begin
         last_io_d = 1'b1;
      end else if (cpu_granted) begin
         last_io_d = 1'b0;
      end
   end
`endif

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ArbIdle;
         rd_owner_q   <= OwnNone;
         starve_cnt_q <= '0;
         burst_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         rd_owner_q   <= rd_owner_d;
         starve_cnt_q <= starve_cnt_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

`ifdef DMEM_ARB_RR_EN
   // Reset as if I/O won last, so the CPU takes the first contended cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_io_q <= 1'b1;
      end else begin
         last_io_q <= last_io_d;
      end
   end
`endif

   // ---------------------------------------------------------------------
   // RAM mux and requester responses
   // ---------------------------------------------------------------------
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_wen;

   always_comb begin
      mem_wen   = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (io_granted) begin
         mem_wen   = bus.io_wen;
         mem_addr  = bus.io_addr;
         mem_wdata = bus.io_wdata;
      end else if (cpu_granted) begin
         mem_wen   = bus.cpu_wen;
         mem_addr  = bus.cpu_addr;
         mem_wdata = bus.cpu_wdata;
      end
   end

   assign bus.mem_wen   = mem_wen;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;

   assign bus.cpu_stall = bus.cpu_req && !cpu_granted;
   assign bus.io_gnt    = io_granted;
   assign bus.io_rvalid = (rd_owner_q == OwnIo);
   assign bus.cpu_rdata = bus.mem_rdata;
   assign bus.io_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed, table-driven bench for dmem_arbiter with a
// behavioural 4K x 32 RAM (write on edge, registered read).
module tb_dmem_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b0;

   always #5 clock = ~clock;

   dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

   dmem_arbiter #(
      .ADDR_W    (12),
      .DATA_W    (32),
      .STARVE_MAX(8),
      .BURST_MAX (4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   logic [31:0] ram [0:4095];

   always @(posedge clock) begin
      if (bus.mem_wen) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   typedef struct {
      logic        cr, cw;
      logic [11:0] ca;
      logic [31:0] cd;
      logic        ir, il, iw;
      logic [11:0] ia;
      logic [31:0] id;
      logic        es, eg, ew;   // expected cpu_stall, io_gnt, mem_wen
      logic [11:0] ea;           // expected mem_addr
      logic [31:0] ed;           // expected mem_wdata
      logic        erv;          // expected io_rvalid
      logic        rchk;         // check read data this cycle
      logic [31:0] erd;          // expected read data
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;
   vec_t tbl[$];

   function automatic vec_t mkv(input logic cr, input logic cw, input logic [11:0] ca,
                                input logic [31:0] cd, input logic ir, input logic il,
                                input logic iw, input logic [11:0] ia, input logic [31:0] id,
                                input logic es, input logic eg, input logic ew,
                                input logic [11:0] ea, input logic [31:0] ed, input logic erv,
                                input logic rchk, input logic [31:0] erd);
      vec_t v;
      v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
      v.ir = ir; v.il = il; v.iw = iw; v.ia = ia; v.id = id;
      v.es = es; v.eg = eg; v.ew = ew; v.ea = ea; v.ed = ed;
      v.erv = erv; v.rchk = rchk; v.erd = erd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, exp);
      end
   endtask

   task automatic drive(input logic cr, input logic cw, input logic [11:0] ca,
                        input logic [31:0] cd, input logic ir, input logic il, input logic iw,
                        input logic [11:0] ia, input logic [31:0] id);
      bus.cpu_req = cr; bus.cpu_wen = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
      bus.io_req = ir; bus.io_lock = il; bus.io_wen = iw; bus.io_addr = ia; bus.io_wdata = id;
   endtask

   task automatic idle();
      drive(0, 0, 12'h000, 32'h0, 0, 0, 0, 12'h000, 32'h0);
   endtask

   // One row per clock cycle: drive at negedge, compare 1 time unit later.
   task automatic run_table(input string tag);
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clock);
         drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
               tbl[i].ir, tbl[i].il, tbl[i].iw, tbl[i].ia, tbl[i].id);
         #1;
         chk($sformatf("%s[%0d] cpu_stall", tag, i), 32'(bus.cpu_stall), 32'(tbl[i].es));
         chk($sformatf("%s[%0d] io_gnt", tag, i), 32'(bus.io_gnt), 32'(tbl[i].eg));
         chk($sformatf("%s[%0d] mem_wen", tag, i), 32'(bus.mem_wen), 32'(tbl[i].ew));
         chk($sformatf("%s[%0d] mem_addr", tag, i), 32'(bus.mem_addr), 32'(tbl[i].ea));
         chk($sformatf("%s[%0d] mem_wdata", tag, i), bus.mem_wdata, tbl[i].ed);
         chk($sformatf("%s[%0d] io_rvalid", tag, i), 32'(bus.io_rvalid), 32'(tbl[i].erv));
         if (tbl[i].rchk) begin
            chk($sformatf("%s[%0d] cpu_rdata", tag, i), bus.cpu_rdata, tbl[i].erd);
            chk($sformatf("%s[%0d] io_rdata", tag, i), bus.io_rdata, tbl[i].erd);
         end
      end
      tbl.delete();
   endtask

   initial begin
      idle();

      // Reset state with no requests
      #12;
      chk("rst mem_wen", 32'(bus.mem_wen), 32'h0);
      chk("rst mem_addr", 32'(bus.mem_addr), 32'h0);
      chk("rst mem_wdata", bus.mem_wdata, 32'h0);
      chk("rst io_gnt", 32'(bus.io_gnt), 32'h0);
      chk("rst cpu_stall", 32'(bus.cpu_stall), 32'h0);
      chk("rst io_rvalid", 32'(bus.io_rvalid), 32'h0);
      @(negedge clock);
      reset = 1'b1;

      // CPU write/read, then I/O write/read of 0x3FF
      tbl.push_back(mkv(1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 0, 12'h000, 32'h0,
                        0, 0, 1, 12'h010, 32'hDEADBEEF, 0, 0, 32'h0));
      tbl.push_back(mkv(1, 0, 12'h010, 32'h0, 0, 0, 0, 12'h000, 32'h0,
                        0, 0, 0, 12'h010, 32'h0, 0, 0, 32'h0));
      tbl.push_back(mkv(0, 0, 12'h000, 32'h0, 0, 0, 0, 12'h000, 32'h0,
                        0, 0, 0, 12'h000, 32'h0, 0, 1, 32'hDEADBEEF));
      tbl.push_back(mkv(0, 0, 12'h000, 32'h0, 1, 0, 1, 12'h3FF, 32'h12345678,
                        0, 1, 1, 12'h3FF, 32'h12345678, 0, 0, 32'h0));
      tbl.push_back(mkv(0, 0, 12'h000, 32'h0, 1, 0, 0, 12'h3FF, 32'h0,
                        0, 1, 0, 12'h3FF, 32'h0, 0, 0, 32'h0));
      tbl.push_back(mkv(0, 0, 12'h000, 32'h0, 0, 0, 0, 12'h000, 32'h0,
                        0, 0, 0, 12'h000, 32'h0, 1, 1, 32'h12345678));
      tbl.push_back(mkv(0, 0, 12'h000, 32'h0, 0, 0, 0, 12'h000, 32'h0,
                        0, 0, 0, 12'h000, 32'h0, 0, 0, 32'h0));
      run_table("basic");

      // Preload 0x100..0x105, then a locked read burst with the CPU waiting
      for (int k = 0; k < 6; k++) begin
         tbl.push_back(mkv(0, 0, 12'h000, 32'h0, 1, 0, 1, 12'(12'h100 + k),
                           32'(32'hB0000100 + k), 0, 1, 1, 12'(12'h100 + k),
                           32'(32'hB0000100 + k), 0, 0, 32'h0));
      end
      tbl.push_back(mkv(0, 0, 12'h000, 32'h0, 1, 1, 0, 12'h100, 32'h0,
                        0, 1, 0, 12'h100, 32'h0, 0, 0, 32'h0));
      for (int k = 1; k < 5; k++) begin
         tbl.push_back(mkv(1, 0, 12'h010, 32'h0, 1, 1, 0, 12'(12'h100 + k), 32'h0,
                           1, 1, 0, 12'(12'h100 + k), 32'h0, 1, 1,
                           32'(32'hB0000100 + k - 1)));
      end
      // Burst limit reached: CPU takes this beat
      tbl.push_back(mkv(1, 0, 12'h010, 32'h0, 1, 1, 0, 12'h105, 32'h0,
                        0, 0, 0, 12'h010, 32'h0, 1, 1, 32'hB0000104));
      tbl.push_back(mkv(0, 0, 12'h000, 32'h0, 1, 1, 0, 12'h105, 32'h0,
                        0, 1, 0, 12'h105, 32'h0, 0, 1, 32'hDEADBEEF));
      tbl.push_back(mkv(0, 0, 12'h000, 32'h0, 0, 0, 0, 12'h000, 32'h0,
                        0, 0, 0, 12'h000, 32'h0, 1, 1, 32'hB0000105));
      tbl.push_back(mkv(0, 0, 12'h000, 32'h0, 0, 0, 0, 12'h000, 32'h0,
                        0, 0, 0, 12'h000, 32'h0, 0, 0, 32'h0));
      run_table("burst");

      // Continuous contention: starvation pattern (or alternation in RR build)
      for (int c = 1; c <= 18; c++) begin
         logic exp_io;
         logic exp_rv;
         @(negedge clock);
         drive(1, 0, 12'h010, 32'h0, 1, 0, 0, 12'h3FF, 32'h0);
         #1;
`ifdef DMEM_ARB_RR_EN
         exp_io = (c % 2 == 0);
         exp_rv = (c > 1) && ((c - 1) % 2 == 0);
`else
         exp_io = (c % 9 == 0);
         exp_rv = (c > 1) && ((c - 1) % 9 == 0);
`endif
         chk($sformatf("contend[%0d] io_gnt", c), 32'(bus.io_gnt), 32'(exp_io));
         chk($sformatf("contend[%0d] cpu_stall", c), 32'(bus.cpu_stall), 32'(exp_io));
         chk($sformatf("contend[%0d] mem_addr", c), 32'(bus.mem_addr),
             exp_io ? 32'h3FF : 32'h010);
         chk($sformatf("contend[%0d] io_rvalid", c), 32'(bus.io_rvalid), 32'(exp_rv));
      end
      @(negedge clock);
      idle();
      #1;
      chk("contend tail io_rvalid", 32'(bus.io_rvalid), 32'h1);
      chk("contend tail io_rdata", bus.io_rdata, 32'h12345678);

      // Reset asserted in the middle of a locked burst with a read pending
      @(negedge clock);
      drive(0, 0, 12'h000, 32'h0, 1, 1, 0, 12'h100, 32'h0);
      #1;
      chk("mid p0 io_gnt", 32'(bus.io_gnt), 32'h1);
      @(negedge clock);
      drive(0, 0, 12'h000, 32'h0, 1, 1, 0, 12'h101, 32'h0);
      #1;
      chk("mid p1 io_gnt", 32'(bus.io_gnt), 32'h1);
      chk("mid p1 io_rvalid", 32'(bus.io_rvalid), 32'h1);
      @(negedge clock);
      idle();
      reset = 1'b0;
      #1;
      chk("mid rst io_rvalid", 32'(bus.io_rvalid), 32'h0);
      chk("mid rst io_gnt", 32'(bus.io_gnt), 32'h0);
      chk("mid rst mem_wen", 32'(bus.mem_wen), 32'h0);
      chk("mid rst mem_addr", 32'(bus.mem_addr), 32'h0);
      @(negedge clock);
      reset = 1'b1;
      // Locked I/O plus CPU right after reset: no burst left over, CPU wins
      drive(1, 0, 12'h010, 32'h0, 1, 1, 0, 12'h102, 32'h0);
      #1;
      chk("post cpu_stall", 32'(bus.cpu_stall), 32'h0);
      chk("post io_gnt", 32'(bus.io_gnt), 32'h0);
      chk("post mem_addr", 32'(bus.mem_addr), 32'h010);
      chk("post io_rvalid", 32'(bus.io_rvalid), 32'h0);
      @(negedge clock);
      drive(0, 0, 12'h000, 32'h0, 1, 0, 0, 12'h3FF, 32'h0);
      #1;
      chk("post io_only io_gnt", 32'(bus.io_gnt), 32'h1);
      chk("post io_only mem_addr", 32'(bus.mem_addr), 32'h3FF);
      chk("post io_only io_rvalid", 32'(bus.io_rvalid), 32'h0);
      chk("post io_only cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
      @(negedge clock);
      idle();
      #1;
      chk("post io_rvalid", 32'(bus.io_rvalid), 32'h1);
      chk("post io_rdata", bus.io_rdata, 32'h12345678);

      @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM (12-bit address, 32-bit data, write on rising edge, read data one cycle after address) between the processor's memory port and an I/O master (breadboard scanner / DMA).
- Sits between processor wren/address_dmem/data/q_dmem and the RAM.
- Grants one requester per cycle, stalls the loser, supports locked I/O bursts and starvation protection.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 32, data width.
- STARVE_MAX, 8, consecutive denied I/O cycles before a forced I/O grant (legal range 1..255).
- BURST_MAX, 4, maximum consecutive locked I/O beats while the CPU is waiting (legal range 1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU memory access this cycle.
- cpu_wen  in  1  CPU write (1) / read (0).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_stall  out  1  CPU request not granted this cycle; hold request.
- cpu_rdata  out  DATA_W  read data for the CPU read granted the previous cycle.
- io_req  in  1  I/O access request.
- io_lock  in  1  I/O requests a burst (keep grant).
- io_wen  in  1  I/O write / read.
- io_addr  in  ADDR_W  I/O address.
- io_wdata  in  DATA_W  I/O write data.
- io_gnt  out  1  I/O access accepted this cycle.
- io_rvalid  out  1  io_rdata valid (I/O read granted the previous cycle).
- io_rdata  out  DATA_W  I/O read data.
- mem_wen  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data (1-cycle latency).

Behaviour:
- Reset (reset low, asynchronous): state=ARB_IDLE, starve_cnt=0, burst_cnt=0, rd_owner=NONE, io_rvalid=0. Grant and mem outputs are combinational; with no requests mem_wen=0, mem_addr=0, mem_wdata=0, io_gnt=0, cpu_stall=0. Reset asserted mid-burst or mid-read drops the burst and any pending io_rvalid.
- Grant decision is combinational from the request inputs plus registered state, and is exactly one-hot or none. mem_* are muxed from the winner. mem_wen = winner_wen & winner_req.
- FSM states, updated on the rising edge:
  - ARB_IDLE: no grant last cycle.
  - ARB_CPU: CPU granted last cycle.
  - ARB_IO: I/O granted last cycle, non-burst.
  - ARB_IO_BURST: I/O holds the lock.
- Grant priority, highest first:
  - (a) state ARB_IO_BURST and io_req and io_lock and (!cpu_req or burst_cnt<BURST_MAX) -> I/O.
  - (b) starve_cnt==STARVE_MAX and io_req -> I/O.
  - (c) cpu_req -> CPU.
  - (d) io_req -> I/O.
- Next state: I/O granted with io_lock -> ARB_IO_BURST. I/O granted without lock -> ARB_IO. CPU granted -> ARB_CPU. No grant -> ARB_IDLE.
- burst_cnt: cleared on entry to ARB_IO_BURST from any other state; increments on each locked I/O grant while cpu_req=1; saturates at BURST_MAX. When (a) fails because burst_cnt==BURST_MAX, the CPU wins that cycle and the burst ends.
- starve_cnt: increments (saturating at STARVE_MAX) each cycle io_req=1 and I/O not granted; cleared on any I/O grant or when io_req=0.
- cpu_stall = cpu_req & !cpu_granted. io_gnt = io_granted.
- Read return: rd_owner is registered from the winner of a read grant (wen=0). Next cycle, io_rvalid=1 iff rd_owner==IO. io_rdata and cpu_rdata both pass mem_rdata directly.
- Writes complete at the edge of grant; no response.
- Simultaneous: cpu_req and io_req both high, no burst, starve_cnt<STARVE_MAX -> CPU wins, I/O waits.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined: rule (c)/(d) ordering alternates. When both request, the requester not granted most recently wins. starve_cnt is held at 0 and rule (b) is removed. Burst rules are unchanged.
- Undefined: fixed CPU priority with starvation counter as above.

Test Plan:
- Reset low mid-burst, then release -> io_rvalid=0, io_gnt=0, mem_wen=0; next io_req only (no lock) granted in the same cycle, no burst continuation.
- CPU write addr 0x010 data 0xDEADBEEF, then CPU read 0x010 -> cpu_stall=0 both cycles; cpu_rdata=0xDEADBEEF one cycle after the read grant; io_rvalid stays 0.
- cpu_req and io_req held high continuously, STARVE_MAX=8 -> CPU granted 8 cycles, I/O granted on cycle 9 with cpu_stall=1 that cycle, then CPU resumes; pattern repeats every 9 cycles.
- I/O locked burst of 6 reads at 0x100..0x105 with cpu_req high, BURST_MAX=4 -> 5 I/O grants (entry beat plus 4 counted), CPU granted on beat 6, I/O then resumes. io_rvalid follows each I/O read grant by exactly 1 cycle.
- io_req alone, read 0x3FF after an I/O write of 0x12345678 -> io_gnt=1 in the request cycle; next cycle io_rvalid=1, io_rdata=0x12345678.
- With DMEM_ARB_RR_EN, both requesting continuously -> grants alternate CPU, I/O, CPU, I/O; cpu_stall toggles 0,1,0,1.
